// File: rtl/temp_conv_pkg.sv
// rtl/temp_conv_pkg.sv - shared types and mode-walk helper for the temperature-conversion sequencer
package temp_conv_pkg;

    localparam int TEMP_W = 4;

    typedef enum logic [1:0] {
        MODE_C = 2'b00,
        MODE_F = 2'b01,
        MODE_K = 2'b10
    } conv_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } seq_state_t;

    localparam logic [1:0] MODE_NONE = 2'b11;

    // cur == MODE_NONE asks for the first enabled mode; a MODE_NONE result means the walk is finished.
    function automatic logic [1:0] next_mode(input logic [2:0] mask, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = MODE_NONE;
        for (int i = 2; i >= 0; i--) begin
            if (mask[i] && (cur == MODE_NONE || i > int'(cur))) begin
                nxt = 2'(i);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/temp_conv_sequencer_if.sv
// rtl/temp_conv_sequencer_if.sv - host and datapath signal bundle of the temperature-conversion sequencer
interface temp_conv_sequencer_if #(
    parameter int TEMP_W = 4
);
    logic [TEMP_W-1:0] temp_in;
    logic              ld;
    logic              st;
    logic              abort;
    logic [2:0]        mode_mask;
    logic [1:0]        man_sel;
    logic [TEMP_W-1:0] conv_temp;
    logic [1:0]        conv_sel;
    logic [TEMP_W-1:0] conv_res;
    logic [TEMP_W-1:0] res_c;
    logic [TEMP_W-1:0] res_f;
    logic [TEMP_W-1:0] res_k;
    logic [2:0]        res_vld;
    logic              busy;
    logic              done;
    logic              alarm;
    logic              alarm_ack;

    modport master (
        output temp_in, ld, st, abort, mode_mask, man_sel, conv_res, alarm_ack,
        input  conv_temp, conv_sel, res_c, res_f, res_k, res_vld, busy, done, alarm
    );

    modport slave (
        input  temp_in, ld, st, abort, mode_mask, man_sel, conv_res, alarm_ack,
        output conv_temp, conv_sel, res_c, res_f, res_k, res_vld, busy, done, alarm
    );
endinterface

// File: rtl/temp_conv_sequencer_dwell_counter.sv
// rtl/temp_conv_sequencer_dwell_counter.sv - per-mode settle counter, last marks the capture cycle
module dwell_counter #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clr,
    input  logic clk,
    input  logic restart,
    input  logic en,
    output logic last
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == LAST_CNT);

    // Wrapping on last lets the next mode start its dwell without an explicit restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/temp_conv_sequencer.sv
// rtl/temp_conv_sequencer.sv - steps the conversion datapath through enabled modes and captures results
// Optional over-temperature alarm enabled by defining TEMP_ALARM_EN.
module temp_conv_sequencer
    import temp_conv_pkg::*;
#(
    parameter int                TEMP_W     = temp_conv_pkg::TEMP_W,
    parameter int                SETTLE_CYC = 2,
    parameter logic [TEMP_W-1:0] ALARM_THR  = TEMP_W'(10)
) (
    input logic                  clk,
    input logic                  clr,
    temp_conv_sequencer_if.slave bus
);
    seq_state_t        state_q, state_d;
    conv_mode_t        mode_q, mode_d;
    logic [2:0]        mask_q, mask_d;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic [TEMP_W-1:0] res_c_q, res_c_d;
    logic [TEMP_W-1:0] res_f_q, res_f_d;
    logic [TEMP_W-1:0] res_k_q, res_k_d;
    logic [2:0]        vld_q, vld_d;
    logic              dwell_last;
    logic [1:0]        nxt;

    dwell_counter #(.SETTLE_CYC(SETTLE_CYC)) u_dwell (
        .clr     (clr),
        .clk     (clk),
        .restart ((state_q != SETTLE) || bus.abort),
        .en      (state_q == SETTLE),
        .last    (dwell_last)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        temp_d  = temp_q;
        res_c_d = res_c_q;
        res_f_d = res_f_q;
        res_k_d = res_k_q;
        vld_d   = vld_q;
        nxt     = MODE_NONE;
        case (state_q)
            IDLE: begin
                if (bus.ld) begin
                    temp_d = bus.temp_in;
                end
                if (bus.st) begin
                    if (bus.mode_mask != 3'b000) begin
                        nxt     = next_mode(bus.mode_mask, MODE_NONE);
                        mask_d  = bus.mode_mask;
                        vld_d   = 3'b000;
                        mode_d  = conv_mode_t'(nxt);
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (dwell_last) begin
                    case (mode_q)
                        MODE_C:  begin res_c_d = bus.conv_res; vld_d[0] = 1'b1; end
                        MODE_F:  begin res_f_d = bus.conv_res; vld_d[1] = 1'b1; end
                        MODE_K:  begin res_k_d = bus.conv_res; vld_d[2] = 1'b1; end
                        default: ;
                    endcase
                    nxt = next_mode(mask_q, mode_q);
                    if (nxt == MODE_NONE) begin
                        state_d = DONE;
                    end else begin
                        mode_d = conv_mode_t'(nxt);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            mode_q  <= MODE_C;
            mask_q  <= 3'b000;
            temp_q  <= '0;
            res_c_q <= '0;
            res_f_q <= '0;
            res_k_q <= '0;
            vld_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            temp_q  <= temp_d;
            res_c_q <= res_c_d;
            res_f_q <= res_f_d;
            res_k_q <= res_k_d;
            vld_q   <= vld_d;
        end
    end

    // Manual select owns the datapath only while idle.
    assign bus.conv_sel  = (state_q == IDLE) ? bus.man_sel : mode_q;
    assign bus.conv_temp = temp_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_f     = res_f_q;
    assign bus.res_k     = res_k_q;
    assign bus.res_vld   = vld_q;
    assign bus.busy      = (state_q == SETTLE);
    assign bus.done      = (state_q == DONE);

`ifdef TEMP_ALARM_EN
    logic ld_seen_q, ld_seen_d;
    logic alarm_q, alarm_d;

    // Threshold is checked on the registered value, one edge after the load.
    always_comb begin
        ld_seen_d = (state_q == IDLE) && bus.ld;
        alarm_d   = alarm_q;
        if (bus.alarm_ack) begin
            alarm_d = 1'b0;
        end
        if (ld_seen_q && (temp_q > ALARM_THR)) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ld_seen_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            ld_seen_q <= ld_seen_d;
            alarm_q   <= alarm_d;
        end
    end

    assign bus.alarm = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm = bus.alarm_ack ^ (|ALARM_THR);
    assign bus.alarm    = 1'b0;
`endif
endmodule

// File: tb/tb_temp_conv_sequencer.sv
// tb/tb_temp_conv_sequencer.sv - directed vector bench for temp_conv_sequencer
module tb_temp_conv_sequencer;

`ifdef TEMP_ALARM_EN
    localparam int ALARM_ON = 1;
`else
    localparam int ALARM_ON = 0;
`endif
    localparam logic [1:0] MAN = 2'b11;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   x;

    temp_conv_sequencer_if #(.TEMP_W(4)) bus ();

    temp_conv_sequencer #(.TEMP_W(4), .SETTLE_CYC(2), .ALARM_THR(4'd10)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Datapath stub: C=x, F=((x*5)>>3)+2, K=x+3
    always_comb begin
        x = int'(bus.conv_temp);
        case (bus.conv_sel)
            2'b00:   bus.conv_res = bus.conv_temp;
            2'b01:   bus.conv_res = 4'(((x * 5) >> 3) + 2);
            2'b10:   bus.conv_res = 4'(x + 3);
            default: bus.conv_res = 4'd0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] temp;
        logic [2:0] mask;
        bit         ld_with_st;
        logic [3:0] c;
        logic [3:0] f;
        logic [3:0] k;
        logic [2:0] vld;
        int         done_cyc;
        int         busy_n;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc, done_n, busy_n;
        if (!v.ld_with_st) begin
            bus.temp_in = v.temp;
            bus.ld      = 1'b1;
            tick();
            bus.ld = 1'b0;
        end
        bus.st        = 1'b1;
        bus.mode_mask = v.mask;
        if (v.ld_with_st) begin
            bus.temp_in = v.temp;
            bus.ld      = 1'b1;
        end
        tick();
        bus.st = 1'b0;
        bus.ld = 1'b0;
        done_cyc = 0;
        done_n   = 0;
        busy_n   = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c < 20) tick();
        end
        check($sformatf("vec%0d done_cycle", idx), done_cyc, v.done_cyc);
        check($sformatf("vec%0d done_width", idx), done_n, 1);
        check($sformatf("vec%0d busy_cycles", idx), busy_n, v.busy_n);
        check($sformatf("vec%0d res_c", idx), int'(bus.res_c), int'(v.c));
        check($sformatf("vec%0d res_f", idx), int'(bus.res_f), int'(v.f));
        check($sformatf("vec%0d res_k", idx), int'(bus.res_k), int'(v.k));
        check($sformatf("vec%0d res_vld", idx), int'(bus.res_vld), int'(v.vld));
        check($sformatf("vec%0d conv_temp", idx), int'(bus.conv_temp), int'(v.temp));
    endtask

    task automatic load(input logic [3:0] t);
        bus.temp_in = t;
        bus.ld      = 1'b1;
        tick();
        bus.ld = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        bus.temp_in   = 4'd0;
        bus.ld        = 1'b0;
        bus.st        = 1'b0;
        bus.abort     = 1'b0;
        bus.mode_mask = 3'b000;
        bus.man_sel   = MAN;
        bus.alarm_ack = 1'b0;
        clr           = 1'b0;

        vecs[0] = '{4'd8,  3'b111, 1'b0, 4'd8, 4'd7,  4'd11, 3'b111, 7, 6};
        vecs[1] = '{4'd8,  3'b100, 1'b0, 4'd8, 4'd7,  4'd11, 3'b100, 3, 2};
        vecs[2] = '{4'd3,  3'b011, 1'b0, 4'd3, 4'd3,  4'd11, 3'b011, 5, 4};
        vecs[3] = '{4'd15, 3'b010, 1'b0, 4'd3, 4'd11, 4'd11, 3'b010, 3, 2};
        vecs[4] = '{4'd0,  3'b101, 1'b1, 4'd0, 4'd11, 4'd3,  3'b101, 5, 4};
        vecs[5] = '{4'd4,  3'b000, 1'b0, 4'd0, 4'd11, 4'd3,  3'b101, 1, 0};

        #1 clr = 1'b1;
        #2;
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        check("rst res_vld", int'(bus.res_vld), 0);
        check("rst res_c", int'(bus.res_c), 0);
        check("rst conv_temp", int'(bus.conv_temp), 0);
        check("rst alarm", int'(bus.alarm), 0);
        check("rst conv_sel", int'(bus.conv_sel), int'(MAN));
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort during the F dwell: C kept, F not captured, no done
        load(4'd8);
        bus.st        = 1'b1;
        bus.mode_mask = 3'b111;
        tick();
        bus.st = 1'b0;
        check("abort sel_c", int'(bus.conv_sel), 0);
        tick();
        tick();
        check("abort sel_f", int'(bus.conv_sel), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort res_vld", int'(bus.res_vld), 1);
        check("abort res_c", int'(bus.res_c), 8);
        check("abort res_f", int'(bus.res_f), 11);
        check("abort conv_sel", int'(bus.conv_sel), int'(MAN));
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 5; c++) begin
                if (bus.done || bus.busy) seen++;
                tick();
            end
            check("abort no_done", seen, 0);
        end

        // ld/st while busy are ignored
        load(4'd2);
        bus.st        = 1'b1;
        bus.mode_mask = 3'b001;
        tick();
        bus.temp_in   = 4'd9;
        bus.ld        = 1'b1;
        bus.mode_mask = 3'b111;
        tick();
        check("busy_ign busy", int'(bus.busy), 1);
        check("busy_ign conv_temp", int'(bus.conv_temp), 2);
        tick();
        bus.st = 1'b0;
        bus.ld = 1'b0;
        check("busy_ign done", int'(bus.done), 1);
        tick();
        tick();
        check("busy_ign idle", int'(bus.busy), 0);
        check("busy_ign res_c", int'(bus.res_c), 2);
        check("busy_ign res_vld", int'(bus.res_vld), 1);
        check("busy_ign conv_temp2", int'(bus.conv_temp), 2);

        // Asynchronous clr in the middle of SETTLE
        load(4'd8);
        bus.st        = 1'b1;
        bus.mode_mask = 3'b111;
        tick();
        bus.st = 1'b0;
        tick();
        tick();
        #2 clr = 1'b1;
        #1;
        check("clr busy", int'(bus.busy), 0);
        check("clr res_c", int'(bus.res_c), 0);
        check("clr res_k", int'(bus.res_k), 0);
        check("clr res_vld", int'(bus.res_vld), 0);
        check("clr conv_temp", int'(bus.conv_temp), 0);
        check("clr conv_sel", int'(bus.conv_sel), int'(MAN));
        #1 clr = 1'b0;
        tick();
        check("clr stays idle", int'(bus.busy) + int'(bus.done), 0);

        // Alarm sequence
        load(4'd11);
        tick();
        check("alarm ld11", int'(bus.alarm), ALARM_ON);
        load(4'd5);
        tick();
        check("alarm ld5", int'(bus.alarm), ALARM_ON);
        bus.alarm_ack = 1'b1;
        tick();
        bus.alarm_ack = 1'b0;
        check("alarm ack", int'(bus.alarm), 0);
        load(4'd10);
        tick();
        check("alarm ld10", int'(bus.alarm), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
